sti_load_sched: RTL and testbench



---
 rtl/sti_pkg.sv | 46 ++++
 rtl/sti_load_sched_if.sv | 54 +++++
 rtl/sti_desc_fifo.sv | 54 +++++
 rtl/sti_load_sched.sv | 168 ++++++++++++++++
 tb/tb_sti_load_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sti_pkg.sv
// sti_pkg: shared types for the STI load scheduler.
//   - Serializer length codes (8/16/24/32-bit words)
//   - desc_t: one queued descriptor {data, length, fill, msb, low, last}
//   - state_t: scheduler FSM states
//   - make_desc(): packs a requester's data/cfg/last into a desc_t
`timescale 1ns/1ps
package sti_pkg;

   localparam logic [1:0] LEN8  = 2'd0;
   localparam logic [1:0] LEN16 = 2'd1;
   localparam logic [1:0] LEN24 = 2'd2;
   localparam logic [1:0] LEN32 = 2'd3;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  length;
      logic        fill;
      logic        msb;
      logic        low;
      logic        last;
   } desc_t;

   typedef enum logic [2:0] {
      ST_PRIME,
      ST_BUSY,
      ST_SHIFT,
      ST_NEXT,
      ST_END,
      ST_DONE
   } state_t;

   // cfg layout is {length[1:0], fill, msb, low}
   function automatic desc_t make_desc(input logic [15:0] data,
                                       input logic [4:0]  cfg,
                                       input logic        last);
      desc_t d;
      d.data   = data;
      d.length = cfg[4:3];
      d.fill   = cfg[2];
      d.msb    = cfg[1];
      d.low    = cfg[0];
      d.last   = last;
      return d;
   endfunction

endpackage

// File: rtl/sti_load_sched_if.sv
// sti_load_sched_if: bundles the two requester channels and the serializer
// side of the STI load scheduler.
//   slave  : the scheduler's view (requests/serializer status in, readys/pi_* out)
//   master : the environment's view (requesters plus serializer)
`timescale 1ns/1ps
interface sti_load_sched_if;

   // requester channels
   logic        req0_valid;
   logic        req0_ready;
   logic [15:0] req0_data;
   logic [4:0]  req0_cfg;
   logic        req0_last;
   logic        req1_valid;
   logic        req1_ready;
   logic [15:0] req1_data;
   logic [4:0]  req1_cfg;
   logic        req1_last;

   // serializer side
   logic        load;
   logic [15:0] pi_data;
   logic [1:0]  pi_length;
   logic        pi_fill;
   logic        pi_msb;
   logic        pi_low;
   logic        pi_end;
   logic        so_valid;
   logic        oem_finish;

   // status
   logic        done;
   logic        err_late;
   logic [7:0]  words_sent;

   modport slave (
      input  req0_valid, req0_data, req0_cfg, req0_last,
      input  req1_valid, req1_data, req1_cfg, req1_last,
      output req0_ready, req1_ready,
      output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
      input  so_valid, oem_finish,
      output done, err_late, words_sent
   );

   modport master (
      output req0_valid, req0_data, req0_cfg, req0_last,
      output req1_valid, req1_data, req1_cfg, req1_last,
      input  req0_ready, req1_ready,
      input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
      output so_valid, oem_finish,
      input  done, err_late, words_sent
   );

endinterface

// File: rtl/sti_desc_fifo.sv
// sti_desc_fifo: synchronous descriptor FIFO with show-ahead head.
//   clk, rst       : clock, asynchronous active-high reset (flushes pointers)
//   push/push_data : write one descriptor (ignored when full unless popping)
//   pop/pop_data   : pop_data is the current head; pop advances it
//   full/empty     : occupancy flags
`timescale 1ns/1ps
module sti_desc_fifo
   import sti_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  desc_t push_data,
   input  logic  pop,
   output desc_t pop_data,
   output logic  full,
   output logic  empty
);

   localparam int AW = $clog2(DEPTH);

   desc_t          mem_reg [DEPTH];
   logic [AW:0]    wr_ptr_reg;
   logic [AW:0]    rd_ptr_reg;
   logic           do_push;
   logic           do_pop;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_pop   = pop && !empty;
   // A pop in the same cycle frees the slot being written, so push-while-full is safe.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem_reg[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // Storage is not reset; only the pointers define valid contents.
   always_ff @(posedge clk) begin
      if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/sti_load_sched.sv
// sti_load_sched: round-robin arbiter, descriptor FIFO and load sequencer for
// the STI serializer.
//   clk, reset : clock, asynchronous active-high reset (aborts the frame)
//   bus        : sti_load_sched_if.slave
//                req0_*/req1_*  descriptor requesters (valid/ready handshake)
//                load, pi_*     descriptor presented to the serializer
//                pi_end         end-of-stream, held once the last word completes
//                so_valid       serializer shift-active, oem_finish completion
//                done, err_late sticky status; words_sent saturating count
`timescale 1ns/1ps
module sti_load_sched
   import sti_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   sti_load_sched_if.slave bus
);

   // ---------------- arbiter ----------------
   logic  rr_ptr_reg;      // 0: requester 0 has priority
   logic  last_seen_reg;
   logic  grant0, grant1;
   logic  acc0, acc1;
   logic  fifo_full, fifo_empty;
   logic  push, pop;
   desc_t push_desc, head_desc;

   always_comb begin
      grant0 = bus.req0_valid && (!rr_ptr_reg || !bus.req1_valid);
      grant1 = bus.req1_valid && ( rr_ptr_reg || !bus.req0_valid);
   end

   assign bus.req0_ready = grant0 && !fifo_full && !last_seen_reg;
   assign bus.req1_ready = grant1 && !fifo_full && !last_seen_reg;
   assign acc0      = bus.req0_valid && bus.req0_ready;
   assign acc1      = bus.req1_valid && bus.req1_ready;
   assign push      = acc0 || acc1;
   assign push_desc = acc1 ? make_desc(bus.req1_data, bus.req1_cfg, bus.req1_last)
                           : make_desc(bus.req0_data, bus.req0_cfg, bus.req0_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_reg    <= 1'b0;
         last_seen_reg <= 1'b0;
      end else begin
         // The winner hands priority to the other requester.
         if (acc0)      rr_ptr_reg <= 1'b1;
         else if (acc1) rr_ptr_reg <= 1'b0;
         if (push && push_desc.last) last_seen_reg <= 1'b1;
      end
   end

   sti_desc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (reset),
      .push      (push),
      .push_data (push_desc),
      .pop       (pop),
      .pop_data  (head_desc),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // ---------------- sequencer ----------------
   state_t      state_reg, state_next;
   desc_t       pi_reg, pi_next;
   logic        load_reg, load_next;
   logic        pi_end_reg, pi_end_next;
   logic        done_reg, done_next;
   logic        err_late_reg, err_late_next;
   logic [7:0]  words_reg, words_next;
   logic        so_valid_q_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_PRIME;
         pi_reg         <= '0;
         load_reg       <= 1'b0;
         pi_end_reg     <= 1'b0;
         done_reg       <= 1'b0;
         err_late_reg   <= 1'b0;
         words_reg      <= 8'd0;
         so_valid_q_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pi_reg         <= pi_next;
         load_reg       <= load_next;
         pi_end_reg     <= pi_end_next;
         done_reg       <= done_next;
         err_late_reg   <= err_late_next;
         words_reg      <= words_next;
         so_valid_q_reg <= bus.so_valid;
      end
   end

   always_comb begin
      state_next    = state_reg;
      pi_next       = pi_reg;
      load_next     = 1'b0;
      pi_end_next   = pi_end_reg;
      done_next     = done_reg;
      words_next    = words_reg;
      pop           = 1'b0;
      // The serializer must not start before the first word has been presented.
      err_late_next = err_late_reg ||
                      (state_reg == ST_PRIME && bus.so_valid && !so_valid_q_reg);

      case (state_reg)
         // First word: the serializer starts on its own, so no load pulse.
         ST_PRIME: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               pi_next    = head_desc;
               state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (bus.so_valid) state_next = ST_SHIFT;
         end
         // SHIFT is only entered with so_valid high, so low here is the fall.
         ST_SHIFT: begin
            if (!bus.so_valid) begin
               if (words_reg != 8'hFF) words_next = words_reg + 8'd1;
               if (pi_reg.last) begin
                  state_next  = ST_END;
                  pi_end_next = 1'b1;
               end else begin
                  state_next  = ST_NEXT;
               end
            end
         end
         ST_NEXT: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               pi_next    = head_desc;
               load_next  = 1'b1;
               state_next = ST_BUSY;
            end
         end
         ST_END: begin
            if (bus.oem_finish) begin
               state_next = ST_DONE;
               done_next  = 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_DONE;
         end
         default: begin
            state_next = ST_PRIME;
         end
      endcase
   end

   assign bus.load       = load_reg;
   assign bus.pi_data    = pi_reg.data;
   assign bus.pi_length  = pi_reg.length;
   assign bus.pi_fill    = pi_reg.fill;
   assign bus.pi_msb     = pi_reg.msb;
   assign bus.pi_low     = pi_reg.low;
   assign bus.pi_end     = pi_end_reg;
   assign bus.done       = done_reg;
   assign bus.err_late   = err_late_reg;
   assign bus.words_sent = words_reg;

endmodule

// File: tb/tb_sti_load_sched.sv
`timescale 1ns/1ps
module tb_sti_load_sched;
   import sti_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ser_so = 1'b0;
   logic tb_so = 1'b0;

   sti_load_sched_if bus();

   sti_load_sched #(.FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.so_valid = ser_so | tb_so;

   int    tests = 0;
   int    fails = 0;
   int    cyc = 0;
   desc_t src0_q[$];
   desc_t src1_q[$];
   desc_t exp_q[$];
   int    acc_log[$];
   bit    acc0_flag, acc1_flag;
   bit    ser_en, kick, chk_turn, last_seen_model;
   int    words_model, load_cnt, last_fall_cyc;

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
      $fatal(1);
   end

   function automatic desc_t rand_desc(input logic [1:0] len, input logic last);
      desc_t d;
      d.data   = 16'($urandom) | 16'h0001;
      d.length = len;
      d.fill   = 1'($urandom);
      d.msb    = 1'($urandom);
      d.low    = 1'($urandom);
      d.last   = last;
      return d;
   endfunction

   function automatic bit pi_is(input desc_t d);
      return (bus.pi_data === d.data) && (bus.pi_length === d.length) &&
             (bus.pi_fill === d.fill) && (bus.pi_msb === d.msb) && (bus.pi_low === d.low);
   endfunction

   // requester drivers: offer the head of each source queue
   initial begin
      bus.req0_valid = 0; bus.req0_data = 0; bus.req0_cfg = 0; bus.req0_last = 0;
      bus.req1_valid = 0; bus.req1_data = 0; bus.req1_cfg = 0; bus.req1_last = 0;
      forever begin
         @(posedge clk); #1;
         if (acc0_flag && src0_q.size() > 0) src0_q.delete(0);
         if (acc1_flag && src1_q.size() > 0) src1_q.delete(0);
         acc0_flag = 0; acc1_flag = 0;
         bus.req0_valid = (src0_q.size() > 0);
         if (src0_q.size() > 0) begin
            bus.req0_data = src0_q[0].data;
            bus.req0_cfg  = {src0_q[0].length, src0_q[0].fill, src0_q[0].msb, src0_q[0].low};
            bus.req0_last = src0_q[0].last;
         end
         bus.req1_valid = (src1_q.size() > 0);
         if (src1_q.size() > 0) begin
            bus.req1_data = src1_q[0].data;
            bus.req1_cfg  = {src1_q[0].length, src1_q[0].fill, src1_q[0].msb, src1_q[0].low};
            bus.req1_last = src1_q[0].last;
         end
      end
   end

   // handshake monitor: builds the expected presentation order
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (bus.load) load_cnt++;
         if (bus.load || bus.pi_end) begin
            tests++;
            if (bus.load && bus.pi_end) begin
               fails++; $display("FAIL load_pi_end_overlap: load=%b pi_end=%b required not both 1", bus.load, bus.pi_end);
            end
         end
         if (last_seen_model) begin
            tests++;
            if (bus.req0_ready || bus.req1_ready) begin
               fails++; $display("FAIL ready_after_last: ready0=%b ready1=%b required 0/0", bus.req0_ready, bus.req1_ready);
            end
         end
         if (bus.req0_valid && bus.req0_ready && src0_q.size() > 0) begin
            acc0_flag = 1; exp_q.push_back(src0_q[0]); acc_log.push_back(0);
            if (src0_q[0].last) last_seen_model = 1;
         end
         if (bus.req1_valid && bus.req1_ready && src1_q.size() > 0) begin
            acc1_flag = 1; exp_q.push_back(src1_q[0]); acc_log.push_back(1);
            if (src1_q[0].last) last_seen_model = 1;
         end
      end
   end

   // serializer model: first word started by kick, later words by load
   initial begin
      desc_t d;
      int    n;
      bit    aborted;
      forever begin
         @(negedge clk);
         if (ser_en && !reset && (kick || bus.load)) begin
            if (kick) begin
               kick = 0;
               repeat (2) @(negedge clk);
               tests++;
               if (bus.load !== 1'b0) begin
                  fails++; $display("FAIL first_word_load: load=%b required 0", bus.load);
               end
            end else if (chk_turn && last_fall_cyc >= 0) begin
               tests++;
               if (cyc - last_fall_cyc != 2) begin
                  fails++; $display("FAIL load_turnaround: %0d cycles after fall, required 2", cyc - last_fall_cyc);
               end
            end
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_word: word started with no accepted descriptor left");
            end else begin
               d = exp_q.pop_front();
               tests++;
               if (!pi_is(d)) begin
                  fails++;
                  $display("FAIL pi_present: got %h/%0d/%b%b%b required %h/%0d/%b%b%b", bus.pi_data, bus.pi_length,
                           bus.pi_fill, bus.pi_msb, bus.pi_low, d.data, d.length, d.fill, d.msb, d.low);
               end
               @(negedge clk);
               tests++;
               if (bus.load !== 1'b0) begin
                  fails++; $display("FAIL load_width: load=%b one cycle later, required 0", bus.load);
               end
               ser_so = 1;
               n = 8 * (int'(d.length) + 1);
               aborted = 0;
               for (int i = 0; i < n; i++) begin
                  @(negedge clk);
                  if (reset) begin aborted = 1; break; end
                  tests++;
                  if (!pi_is(d)) begin
                     fails++;
                     $display("FAIL pi_stable: got %h/%0d/%b%b%b required %h/%0d/%b%b%b", bus.pi_data, bus.pi_length,
                              bus.pi_fill, bus.pi_msb, bus.pi_low, d.data, d.length, d.fill, d.msb, d.low);
                  end
               end
               ser_so = 0;
               if (!aborted) begin
                  last_fall_cyc = cyc;
                  words_model++;
                  @(negedge clk);
                  tests++;
                  if (bus.pi_end !== d.last) begin
                     fails++; $display("FAIL pi_end_after_fall: pi_end=%b required %b", bus.pi_end, d.last);
                  end
               end
            end
         end
      end
   end

   task automatic do_reset();
      ser_en = 0; kick = 0; chk_turn = 0;
      reset = 1;
      src0_q.delete(); src1_q.delete(); exp_q.delete(); acc_log.delete();
      acc0_flag = 0; acc1_flag = 0; last_seen_model = 0;
      words_model = 0; load_cnt = 0; last_fall_cyc = -1;
      tb_so = 0; bus.oem_finish = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1;
      @(negedge clk);
      tests++; if (bus.load !== 1'b0) begin fails++; $display("FAIL rst_load: got %b required 0", bus.load); end
      tests++; if (bus.pi_data !== 16'h0) begin fails++; $display("FAIL rst_pi_data: got %h required 0000", bus.pi_data); end
      tests++; if ({bus.pi_length, bus.pi_fill, bus.pi_msb, bus.pi_low} !== 5'h0) begin
         fails++; $display("FAIL rst_pi_cfg: got %b%b%b%b required 00000", bus.pi_length, bus.pi_fill, bus.pi_msb, bus.pi_low); end
      tests++; if ({bus.pi_end, bus.done, bus.err_late} !== 3'b000) begin
         fails++; $display("FAIL rst_flags: pi_end/done/err_late=%b%b%b required 000", bus.pi_end, bus.done, bus.err_late); end
      tests++; if (bus.words_sent !== 8'd0) begin fails++; $display("FAIL rst_words: got %0d required 0", bus.words_sent); end
      reset = 0;
      repeat (3) @(negedge clk);
      tests++; if ({bus.load, bus.pi_end, bus.done} !== 3'b000) begin
         fails++; $display("FAIL idle_after_rst: load/pi_end/done=%b%b%b required 000", bus.load, bus.pi_end, bus.done); end
   endtask

   task automatic test_single_last();
      desc_t d;
      do_reset();
      d = make_desc(16'hA5C3, 5'b01010, 1'b1);
      src0_q.push_back(d);
      ser_en = 1;
      for (int i = 0; i < 50 && acc_log.size() < 1; i++) @(negedge clk);
      tests++; if (acc_log.size() != 1) begin fails++; $display("FAIL single_accept: %0d accepts required 1", acc_log.size()); end
      kick = 1;
      for (int i = 0; i < 200 && words_model < 1; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      tests++; if (words_model != 1) begin fails++; $display("FAIL single_word_timeout: %0d words required 1", words_model); end
      tests++; if (bus.pi_end !== 1'b1) begin fails++; $display("FAIL single_pi_end: got %b required 1", bus.pi_end); end
      tests++; if (bus.words_sent !== 8'd1) begin fails++; $display("FAIL single_words: got %0d required 1", bus.words_sent); end
      tests++; if (load_cnt != 0) begin fails++; $display("FAIL single_no_load: %0d loads required 0", load_cnt); end
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL single_early_done: got %b required 0", bus.done); end
      tests++; if (bus.err_late !== 1'b0) begin fails++; $display("FAIL single_err_late: got %b required 0", bus.err_late); end
      bus.oem_finish = 1;
      @(negedge clk);
      bus.oem_finish = 0;
      tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL single_done: got %b required 1", bus.done); end
      repeat (4) @(negedge clk);
      tests++; if ({bus.done, bus.pi_end} !== 2'b11) begin
         fails++; $display("FAIL single_sticky: done/pi_end=%b%b required 11", bus.done, bus.pi_end); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         src0_q.push_back(rand_desc(2'($urandom_range(0, 3)), 1'b0));
         src1_q.push_back(rand_desc(2'($urandom_range(0, 3)), 1'b0));
      end
      repeat (14) @(negedge clk);
      // one word in the presentation register plus a full FIFO of 4
      tests++; if (acc_log.size() != 5) begin fails++; $display("FAIL rr_fill_count: %0d accepts required 5", acc_log.size()); end
      tests++; if (bus.req0_ready || bus.req1_ready) begin
         fails++; $display("FAIL rr_full_ready: ready0=%b ready1=%b required 0/0", bus.req0_ready, bus.req1_ready); end
      ser_en = 1; kick = 1;
      for (int i = 0; i < 1500 && words_model < 8; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      tests++; if (words_model != 8) begin fails++; $display("FAIL rr_words_timeout: %0d words required 8", words_model); end
      tests++; if (acc_log.size() != 8) begin fails++; $display("FAIL rr_total: %0d accepts required 8", acc_log.size()); end
      for (int i = 0; i < acc_log.size(); i++) begin
         tests++;
         if (acc_log[i] != i % 2) begin fails++; $display("FAIL rr_order: accept %0d from r%0d required r%0d", i, acc_log[i], i % 2); end
      end
      tests++; if (bus.words_sent !== 8'd8) begin fails++; $display("FAIL rr_words: got %0d required 8", bus.words_sent); end
      tests++; if (bus.pi_end !== 1'b0) begin fails++; $display("FAIL rr_pi_end: got %b required 0", bus.pi_end); end
   endtask

   task automatic test_lengths();
      do_reset();
      src0_q.push_back(rand_desc(LEN8, 1'b0));
      src0_q.push_back(rand_desc(LEN24, 1'b0));
      src0_q.push_back(rand_desc(LEN32, 1'b1));
      for (int i = 0; i < 50 && acc_log.size() < 3; i++) @(negedge clk);
      tests++; if (acc_log.size() != 3) begin fails++; $display("FAIL len_accepts: %0d accepts required 3", acc_log.size()); end
      repeat (2) @(negedge clk);
      chk_turn = 1; ser_en = 1; kick = 1;
      for (int i = 0; i < 600 && words_model < 3; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      tests++; if (words_model != 3) begin fails++; $display("FAIL len_words_timeout: %0d words required 3", words_model); end
      tests++; if (load_cnt != 2) begin fails++; $display("FAIL len_loads: %0d loads required 2", load_cnt); end
      tests++; if (bus.words_sent !== 8'd3) begin fails++; $display("FAIL len_words: got %0d required 3", bus.words_sent); end
      tests++; if (bus.pi_end !== 1'b1) begin fails++; $display("FAIL len_pi_end: got %b required 1", bus.pi_end); end
      bus.oem_finish = 1;
      @(negedge clk);
      bus.oem_finish = 0;
      tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL len_done: got %b required 1", bus.done); end
   endtask

   task automatic test_err_late();
      do_reset();
      @(negedge clk);
      tests++; if (bus.err_late !== 1'b0) begin fails++; $display("FAIL err_before: got %b required 0", bus.err_late); end
      tb_so = 1;
      repeat (2) @(negedge clk);
      tests++; if (bus.err_late !== 1'b1) begin fails++; $display("FAIL err_set: got %b required 1", bus.err_late); end
      tb_so = 0;
      repeat (5) @(negedge clk);
      tests++; if (bus.err_late !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b required 1", bus.err_late); end
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL err_done: got %b required 0", bus.done); end
   endtask

   task automatic test_last_from_req1();
      do_reset();
      for (int i = 0; i < 3; i++) src0_q.push_back(rand_desc(2'($urandom_range(0, 3)), 1'b0));
      src1_q.push_back(rand_desc(2'($urandom_range(0, 3)), 1'b0));
      src1_q.push_back(rand_desc(2'($urandom_range(0, 3)), 1'b1));
      ser_en = 1;
      for (int i = 0; i < 50 && acc_log.size() < 1; i++) @(negedge clk);
      kick = 1;
      for (int i = 0; i < 800 && words_model < 4; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      tests++; if (words_model != 4) begin fails++; $display("FAIL last_words_timeout: %0d words required 4", words_model); end
      tests++; if (acc_log.size() != 4) begin fails++; $display("FAIL last_accepts: %0d accepts required 4", acc_log.size()); end
      for (int i = 0; i < acc_log.size(); i++) begin
         tests++;
         if (acc_log[i] != i % 2) begin fails++; $display("FAIL last_order: accept %0d from r%0d required r%0d", i, acc_log[i], i % 2); end
      end
      tests++; if (bus.req0_valid !== 1'b1 || bus.req0_ready !== 1'b0) begin
         fails++; $display("FAIL last_r0_blocked: valid=%b ready=%b required 1/0", bus.req0_valid, bus.req0_ready); end
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL last_early_done: got %b required 0", bus.done); end
      bus.oem_finish = 1;
      @(negedge clk);
      bus.oem_finish = 0;
      tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL last_done: got %b required 1", bus.done); end
   endtask

   task automatic test_reset_mid_shift();
      do_reset();
      for (int i = 0; i < 3; i++) src0_q.push_back(rand_desc(LEN16, 1'b0));
      ser_en = 1;
      for (int i = 0; i < 50 && acc_log.size() < 1; i++) @(negedge clk);
      kick = 1;
      for (int i = 0; i < 200 && !(words_model == 1 && bus.so_valid); i++) @(negedge clk);
      repeat (3) @(negedge clk);
      tests++; if (bus.words_sent !== 8'd1) begin fails++; $display("FAIL mid_words_before: got %0d required 1", bus.words_sent); end
      #2 reset = 1;
      #1;
      tests++; if (bus.pi_data !== 16'h0) begin fails++; $display("FAIL mid_pi_data: got %h required 0000", bus.pi_data); end
      tests++; if (bus.words_sent !== 8'd0) begin fails++; $display("FAIL mid_words: got %0d required 0", bus.words_sent); end
      tests++; if ({bus.load, bus.pi_end, bus.done, bus.err_late, bus.pi_length} !== 6'h0) begin
         fails++; $display("FAIL mid_flags: load/pi_end/done/err/len=%b%b%b%b%b required 000000",
                           bus.load, bus.pi_end, bus.done, bus.err_late, bus.pi_length); end
      do_reset();
      repeat (6) @(negedge clk);
      // a leftover FIFO entry would be popped into pi_data here
      tests++; if (bus.pi_data !== 16'h0) begin fails++; $display("FAIL mid_fifo_flushed: pi_data %h required 0000", bus.pi_data); end
      tests++; if (bus.words_sent !== 8'd0) begin fails++; $display("FAIL mid_no_resume: words %0d required 0", bus.words_sent); end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 258; i++) src0_q.push_back(rand_desc(LEN8, 1'b0));
      ser_en = 1;
      for (int i = 0; i < 50 && acc_log.size() < 1; i++) @(negedge clk);
      kick = 1;
      for (int i = 0; i < 6000 && words_model < 258; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      tests++; if (words_model != 258) begin fails++; $display("FAIL sat_timeout: %0d words required 258", words_model); end
      tests++; if (bus.words_sent !== 8'd255) begin fails++; $display("FAIL sat_words: got %0d required 255", bus.words_sent); end
   endtask

   initial begin
      test_reset();
      test_single_last();
      test_round_robin();
      test_lengths();
      test_err_late();
      test_last_from_req1();
      test_reset_mid_shift();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
